// File: rtl/shot_clock_ctrl_if.sv
// shot_clock_ctrl_if: run/reload controls and display/alarm outputs of one shot clock
interface shot_clock_ctrl_if #(parameter int DIGITS = 2);
  logic nPAUSE;
  logic reload;
  logic [4*DIGITS-1:0] timer_bcd;
  logic [7*DIGITS-1:0] oSEG;
  logic Alarm;
  logic tick;
  modport master (output nPAUSE, reload, input timer_bcd, oSEG, Alarm, tick);
  modport slave (input nPAUSE, reload, output timer_bcd, oSEG, Alarm, tick);
endinterface

// File: rtl/shot_clock_ctrl.sv
// shot_clock_ctrl: prescaled BCD countdown with run/hold, reload, timed expiry alarm and active-low 7-seg
// Define SHOT_CLOCK_FLASH_EN to blink the display on every tick while the alarm is active.
module shot_clock_ctrl #(
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int DIGITS = 2,
  parameter logic [4*DIGITS-1:0] START_VAL = 'h24,
  parameter int ALARM_TICKS = 3
) (
  input logic CLK_50,
  input logic nRST,
  shot_clock_ctrl_if.slave bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);
  localparam logic [4*DIGITS-1:0] ONE = (4*DIGITS)'(1);
  typedef enum logic [1:0] {HOLD, RUN, EXPIRED} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] psc_q, psc_d;
  logic [4*DIGITS-1:0] timer_q, timer_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic alarm_q, alarm_d, tick_q, tick_d, blank;
  logic [7*DIGITS-1:0] seg;
  function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
    logic b;
    b = 1'b1;
    bcd_dec = v;
    for (int k = 0; k < DIGITS; k++) begin
      bcd_dec[4*k+:4] = !b ? v[4*k+:4] : v[4*k+:4] == 4'd0 ? 4'd9 : v[4*k+:4] - 4'd1;
      b = b && v[4*k+:4] == 4'd0;
    end
  endfunction
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction
  always_comb begin
    state_d = state_q;
    psc_d = psc_q;
    timer_d = timer_q;
    acnt_d = acnt_q;
    alarm_d = alarm_q;
    if (bus.reload) begin
      state_d = HOLD;
      psc_d = '0;
      timer_d = START_VAL;
      acnt_d = '0;
      alarm_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: state_d = bus.nPAUSE ? RUN : HOLD;
        RUN: begin
          state_d = bus.nPAUSE ? RUN : HOLD;
          psc_d = tick_q ? '0 : bus.nPAUSE ? psc_q + PW'(1) : psc_q;
          if (tick_q && timer_q == ONE) begin
            state_d = EXPIRED;
            timer_d = '0;
            acnt_d = '0;
            alarm_d = 1'b1;
          end else if (tick_q) begin
            timer_d = bcd_dec(timer_q);
          end
        end
        EXPIRED: begin
          psc_d = tick_q ? '0 : psc_q + PW'(1);
          if (tick_q && alarm_q) begin
            acnt_d = acnt_q + AW'(1);
            alarm_d = acnt_d != AW'(ALARM_TICKS);
          end
        end
        default: state_d = HOLD;
      endcase
    end
    tick_d = state_d != HOLD && psc_d == TERM;
  end
  always_ff @(posedge CLK_50) begin
    if (!nRST) begin
      state_q <= HOLD;
      psc_q <= '0;
      timer_q <= START_VAL;
      acnt_q <= '0;
      alarm_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q <= psc_d;
      timer_q <= timer_d;
      acnt_q <= acnt_d;
      alarm_q <= alarm_d;
      tick_q <= tick_d;
    end
  end
`ifdef SHOT_CLOCK_FLASH_EN
  logic flash_q, flash_d;
  // set blank on the expiring tick, toggle per alarm tick, cleared as the alarm drops
  always_comb flash_d = bus.reload ? 1'b0 :
                        (state_q == RUN && tick_q && timer_q == ONE) ? 1'b1 :
                        (state_q == EXPIRED && tick_q && alarm_q) ? alarm_d & ~flash_q : flash_q;
  always_ff @(posedge CLK_50) flash_q <= nRST ? flash_d : 1'b0;
  assign blank = flash_q;
`else
  assign blank = 1'b0;
`endif
  always_comb begin
    seg = '1;
    for (int k = 0; k < DIGITS; k++) seg[7*k+:7] = blank ? 7'h7F : seg7(timer_q[4*k+:4]);
  end
  assign bus.timer_bcd = timer_q;
  assign bus.oSEG = seg;
  assign bus.Alarm = alarm_q;
  assign bus.tick = tick_q;
endmodule

// File: tb/tb_shot_clock_ctrl.sv
// tb_shot_clock_ctrl: directed checks of shot_clock_ctrl against an integer-level model of the clock
module tb_shot_clock_ctrl;
  localparam int PER = 10;
  localparam int ALARM = 3;
  localparam logic [6:0] GLY [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic clk = 1'b0;
  logic nrst = 1'b0;
  bit go = 1'b0;
  int vec = 0;
  int miss = 0;
  int m_val = 24, m_psc = 0, m_md = 0, m_lf = 0;
  bit m_al = 1'b0, m_fl = 1'b0;
  shot_clock_ctrl_if #(.DIGITS(2)) a();
  shot_clock_ctrl_if #(.DIGITS(3)) b();
  shot_clock_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .START_VAL(8'h24), .ALARM_TICKS(ALARM))
    dut (.CLK_50(clk), .nRST(nrst), .bus(a));
  shot_clock_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(3), .START_VAL(12'h100), .ALARM_TICKS(ALARM))
    dut3 (.CLK_50(clk), .nRST(nrst), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  function automatic logic [13:0] seg_of(input int v, input bit bl);
    return bl ? 14'h3FFF : {~GLY[v / 10], ~GLY[v % 10]};
  endfunction
  // model: decimal count, prescaler position, mode 0=hold 1=run 2=expired, alarm ticks left
  always @(posedge clk) begin : model
    int v, p, md, lf;
    bit al, fl, t;
    v = m_val; p = m_psc; md = m_md; lf = m_lf; al = m_al; fl = m_fl;
    t = md != 0 && p == PER - 1;
    if (!nrst || a.reload) begin
      v = 24; p = 0; md = 0; lf = 0; al = 0; fl = 0;
    end else if (md == 0) begin
      md = a.nPAUSE ? 1 : 0;
    end else if (md == 1) begin
      if (t) begin
        p = 0;
        if (v == 1) begin v = 0; md = 2; al = 1; lf = ALARM; fl = 1; end
        else v = v - 1;
      end else if (a.nPAUSE) p = p + 1;
      if (md == 1 && !a.nPAUSE) md = 0;
    end else begin
      p = t ? 0 : p + 1;
      if (t && al) begin lf = lf - 1; al = lf != 0; fl = al && !fl; end
    end
    m_val <= v; m_psc <= p; m_md <= md; m_lf <= lf; m_al <= al; m_fl <= fl;
  end
  always @(negedge clk) begin
    if (go) begin
      bit bl;
`ifdef SHOT_CLOCK_FLASH_EN
      bl = m_fl;
`else
      bl = 1'b0;
`endif
      chk("timer", 32'(a.timer_bcd), 32'(to_bcd(m_val)));
      chk("seg", 32'(a.oSEG), 32'(seg_of(m_val, bl)));
      chk("alarm", 32'(a.Alarm), 32'(m_al));
      chk("tick", 32'(a.tick), 32'(m_md != 0 && m_psc == PER - 1));
    end
  end
  initial begin
    int n, cnt;
    a.nPAUSE = 1'b0; a.reload = 1'b0;
    b.nPAUSE = 1'b0; b.reload = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    go = 1'b1;
    chk("rst_timer", 32'(a.timer_bcd), 32'h24);
    chk("rst_tick", 32'(a.tick), 32'h0);
    chk("rst_alarm", 32'(a.Alarm), 32'h0);
    a.nPAUSE = 1'b1; b.nPAUSE = 1'b1;
    n = 0;
    while (!a.tick && n < 50) begin @(negedge clk); n++; end
    chk("first_tick_cycles", 32'(n), 32'd10);
    @(negedge clk);
    chk("first_dec", 32'(a.timer_bcd), 32'h23);
    chk("first_seg", 32'(a.oSEG), 32'({7'h24, 7'h30}));
    chk("borrow3_timer", 32'(b.timer_bcd), 32'h099);
    chk("borrow3_seg", 32'(b.oSEG), 32'({7'h40, 7'h10, 7'h10}));
    n = 0;
    while (!(m_md == 1 && m_psc == 6) && n < 50) begin @(negedge clk); n++; end
    chk("pause_reach", 32'(n < 50), 32'd1);
    a.nPAUSE = 1'b0;
    repeat (50) @(negedge clk);
    chk("hold_timer", 32'(a.timer_bcd), 32'h23);
    a.nPAUSE = 1'b1;
    n = 0;
    while (!a.tick && n < 50) begin @(negedge clk); n++; end
    chk("resume_cycles", 32'(n), 32'd4);
    n = 0;
    while (!(m_val == 5 && m_md == 1 && m_psc == PER - 1) && n < 400) begin @(negedge clk); n++; end
    chk("reach_05_tick", 32'(a.tick && a.timer_bcd == 8'h05), 32'd1);
    a.reload = 1'b1;
    @(negedge clk);
    a.reload = 1'b0;
    chk("reload_tick_timer", 32'(a.timer_bcd), 32'h24);
    chk("reload_tick_alarm", 32'(a.Alarm), 32'h0);
    chk("reload_tick_tick", 32'(a.tick), 32'h0);
    n = 0;
    while (!a.Alarm && n < 400) begin @(negedge clk); n++; end
    chk("expire_timer", 32'(a.timer_bcd), 32'h00);
    chk("expire_alarm", 32'(a.Alarm), 32'h1);
    cnt = 0; n = 0;
    while (a.Alarm && n < 100) begin
      if (a.tick) cnt++;
      @(negedge clk);
      a.nPAUSE = ~a.nPAUSE;
      n++;
    end
    chk("alarm_ticks", 32'(cnt), 32'(ALARM));
    repeat (25) begin @(negedge clk); a.nPAUSE = ~a.nPAUSE; end
    chk("expired_hold0", 32'(a.timer_bcd), 32'h00);
    chk("expired_seg0", 32'(a.oSEG), 32'({7'h40, 7'h40}));
    a.nPAUSE = 1'b1;
    a.reload = 1'b1;
    @(negedge clk);
    a.reload = 1'b0;
    n = 0;
    while (!a.Alarm && n < 400) begin @(negedge clk); n++; end
    @(negedge clk);
    a.reload = 1'b1;
    @(negedge clk);
    a.reload = 1'b0;
    chk("reload_alarm_off", 32'(a.Alarm), 32'h0);
    chk("reload_alarm_timer", 32'(a.timer_bcd), 32'h24);
    n = 0;
    while (a.timer_bcd != 8'h11 && n < 400) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    a.nPAUSE = 1'b0;
    chk("reset_run_timer", 32'(a.timer_bcd), 32'h24);
    chk("reset_run_tick", 32'(a.tick), 32'h0);
    chk("reset_run_alarm", 32'(a.Alarm), 32'h0);
    repeat (20) @(negedge clk);
    chk("reset_hold_timer", 32'(a.timer_bcd), 32'h24);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
